// File: rtl/ex_mul_unit_if.sv
// EX-stage multiplier bus: ID_EX operands in, stall/done/result back to the pipeline.
// done_o is the only valid qualifier for result_o/rd_o; stall_o holds the upstream stages.
interface ex_mul_unit_if #(
    parameter int WIDTH = 32
);
    logic             ALUOp_i;
    logic [9:0]       funct_i;
    logic [4:0]       rd_i;
    logic [WIDTH-1:0] reg1Data_i;
    logic [WIDTH-1:0] reg2Data_i;
    logic             stall_o;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] result_o;
    logic [4:0]       rd_o;
    // Debug view of the FSM: 0 = IDLE, 1 = BUSY, 2 = DONE.
    logic [1:0]       state_o;

    modport slave (
        input  ALUOp_i, funct_i, rd_i, reg1Data_i, reg2Data_i,
        output stall_o, busy_o, done_o, result_o, rd_o, state_o
    );

    modport master (
        output ALUOp_i, funct_i, rd_i, reg1Data_i, reg2Data_i,
        input  stall_o, busy_o, done_o, result_o, rd_o, state_o
    );
endinterface

// File: rtl/ex_mul_unit.sv
// Iterative shift-add multiplier (low WIDTH bits) for the EX stage; fixed WIDTH iterations,
// stalls the pipeline while working and pulses done_o for one cycle with the result.
module ex_mul_unit #(
    parameter int WIDTH = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    ex_mul_unit_if.slave  bus
);
    localparam int         CNT_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [9:0] FUNCT_MUL = 10'b0000001_000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]   acc_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [4:0]         rd_q;
    logic [WIDTH-1:0]   result_q;
    logic [4:0]         rd_out_q;
    logic               busy_q;
    logic               done_q;
    logic               is_mul;

    assign is_mul = bus.ALUOp_i && (bus.funct_i == FUNCT_MUL);
    assign acc_d  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            rd_q     <= '0;
            result_q <= '0;
            rd_out_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (is_mul) begin
                        mcand_q  <= bus.reg1Data_i;
                        mplier_q <= bus.reg2Data_i;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        rd_q     <= bus.rd_i;
                        busy_q   <= 1'b1;
                        state_q  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    // Last iteration: register the final sum so DONE presents it directly.
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        result_q <= acc_d;
                        rd_out_q <= rd_q;
                        state_q  <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Combinational so the mul is held in EX from its very first cycle.
    assign bus.stall_o  = rst_i && (((state_q == S_IDLE) && is_mul) || (state_q == S_BUSY));
    assign bus.busy_o   = busy_q;
    assign bus.done_o   = done_q;
    assign bus.result_o = result_q;
    assign bus.rd_o     = rd_out_q;
    assign bus.state_o  = state_q;
endmodule
